// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO in front of it.
// Frames go out as start, DATA_W data bits LSB first, an optional parity bit,
// then STOP_BITS stop bits. Each bit lasts baud_div+1 txclk cycles, using the
// divisor value captured when the frame starts.
module uart_tx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          txclk,
    input  logic                          reset,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    input  logic                          txenable,
    input  logic                          clr_ovf,
    output logic                          txout,
    output logic                          busy,
    output logic                          txempty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              txout_q, txout_d;
    logic              busy_q, busy_d;
    logic              txempty_q, txempty_d;
    logic              wr_ready_q, wr_ready_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic full_c;
    logic push_c;
    logic drop_c;
    logic pop_c;
    logic tick_c;
    logic par_c;

    // Next-state: FIFO bookkeeping, frame sequencing and registered outputs.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        pop_c      = 1'b0;

        // Full is judged from registered occupancy so a same-edge pop never makes room.
        full_c = (count_q == CW'(FIFO_DEPTH));
        push_c = wr_en && !full_c;
        drop_c = wr_en && full_c;
        tick_c = (cnt_q == div_q);

        case (state_q)
            IDLE: begin
                if (txenable && (count_q != '0)) begin
                    pop_c = 1'b1;
                end
            end
            START: begin
                if (tick_c) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            DATA: begin
                if (tick_c) begin
                    cnt_d = '0;
                    if (bit_q == BW'(DATA_W - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            PAR: begin
                if (tick_c) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            STOP: begin
                if (tick_c) begin
                    cnt_d = '0;
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        // Chain straight into the next frame when allowed: no idle gap.
                        if (txenable && (count_q != '0)) begin
                            pop_c = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop_c) begin
            data_d   = mem_q[rd_ptr_q];
            div_d    = baud_div;
            cnt_d    = '0;
            bit_d    = '0;
            state_d  = START;
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A dropped push outranks a clear on the same edge.
        if (drop_c) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end

        par_c = (PARITY == 1) ? ~(^data_d) : (^data_d);

        case (state_d)
            START:   txout_d = 1'b0;
            DATA:    txout_d = data_d[bit_d];
            PAR:     txout_d = par_c;
            default: txout_d = 1'b1;
        endcase

        busy_d     = (state_d != IDLE);
        txempty_d  = (count_d == '0) && (state_d == IDLE);
        wr_ready_d = (count_d != CW'(FIFO_DEPTH));
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge txclk) begin
        if (!reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            bit_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            txout_q    <= 1'b1;
            busy_q     <= 1'b0;
            txempty_q  <= 1'b1;
            wr_ready_q <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            txout_q    <= txout_d;
            busy_q     <= busy_d;
            txempty_q  <= txempty_d;
            wr_ready_q <= wr_ready_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge txclk) begin
        if (reset && push_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign txout      = txout_q;
    assign busy       = busy_q;
    assign txempty    = txempty_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (no parity / even parity with two
// stop bits / odd parity) share one stimulus stream and are compared every
// cycle against a queue-based model that builds each frame as a bit list.
module tb_uart_tx_fifo;

    localparam int unsigned NI    = 3;
    localparam int unsigned DEPTH = 4;

    logic        txclk;
    logic        reset;
    logic [15:0] baud_div;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        txenable;
    logic        clr_ovf;

    logic [NI-1:0] wr_ready_v;
    logic [NI-1:0] txout_v;
    logic [NI-1:0] busy_v;
    logic [NI-1:0] txempty_v;
    logic [NI-1:0] ovf_v;
    logic [2:0]    cnt0, cnt1, cnt2;

    int vectors;
    int miscompares;

    // Model state per instance
    logic [7:0]  q_m     [NI][$];
    bit          busy_m  [NI];
    bit          ovf_m   [NI];
    logic [15:0] frame_m [NI];
    int          nbits_m [NI];
    int          bdiv_m  [NI];
    int          t_m     [NI];
    bit          valid;

    int par_k  [NI] = '{0, 2, 1};
    int stop_k [NI] = '{1, 2, 1};

    uart_tx_fifo #(.DATA_W(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16), .FIFO_DEPTH(DEPTH)) u0 (
        .txclk(txclk), .reset(reset), .baud_div(baud_div), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(wr_ready_v[0]), .txenable(txenable), .clr_ovf(clr_ovf), .txout(txout_v[0]),
        .busy(busy_v[0]), .txempty(txempty_v[0]), .fifo_count(cnt0), .overflow(ovf_v[0]));

    uart_tx_fifo #(.DATA_W(8), .PARITY(2), .STOP_BITS(2), .DIV_W(16), .FIFO_DEPTH(DEPTH)) u1 (
        .txclk(txclk), .reset(reset), .baud_div(baud_div), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(wr_ready_v[1]), .txenable(txenable), .clr_ovf(clr_ovf), .txout(txout_v[1]),
        .busy(busy_v[1]), .txempty(txempty_v[1]), .fifo_count(cnt1), .overflow(ovf_v[1]));

    uart_tx_fifo #(.DATA_W(8), .PARITY(1), .STOP_BITS(1), .DIV_W(16), .FIFO_DEPTH(DEPTH)) u2 (
        .txclk(txclk), .reset(reset), .baud_div(baud_div), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(wr_ready_v[2]), .txenable(txenable), .clr_ovf(clr_ovf), .txout(txout_v[2]),
        .busy(busy_v[2]), .txempty(txempty_v[2]), .fifo_count(cnt2), .overflow(ovf_v[2]));

    initial txclk = 1'b0;
    always #5 txclk = ~txclk;

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d @%0t: got %0h expected %0h", nm, k, $time, got, exp);
        end
    endtask

    function automatic logic [2:0] get_cnt(input int k);
        if (k == 0) return cnt0;
        if (k == 1) return cnt1;
        return cnt2;
    endfunction

    // Frame = start, 8 data bits LSB first, optional parity, stop bits.
    task automatic start_frame(input int k, input logic [7:0] b);
        int n;
        int ones;
        frame_m[k] = '0;
        frame_m[k][0] = 1'b0;
        for (int i = 0; i < 8; i++) frame_m[k][1 + i] = b[i];
        n = 9;
        if (par_k[k] != 0) begin
            ones = $countones(b);
            if (par_k[k] == 1) frame_m[k][n] = ((ones % 2) == 0);
            else               frame_m[k][n] = ((ones % 2) == 1);
            n++;
        end
        for (int j = 0; j < stop_k[k]; j++) frame_m[k][n + j] = 1'b1;
        nbits_m[k] = n + stop_k[k];
        bdiv_m[k]  = int'(baud_div) + 1;
        t_m[k]     = 0;
        busy_m[k]  = 1'b1;
    endtask

    task automatic model_step(input int k);
        bit full;
        bit do_pop;
        logic [7:0] b;
        if (!reset) begin
            q_m[k].delete();
            busy_m[k] = 1'b0;
            ovf_m[k]  = 1'b0;
            t_m[k]    = 0;
            return;
        end
        full   = (q_m[k].size() == DEPTH);
        do_pop = 1'b0;
        if (busy_m[k]) begin
            if (t_m[k] == nbits_m[k] * bdiv_m[k] - 1) begin
                busy_m[k] = 1'b0;
                do_pop = txenable && (q_m[k].size() > 0);
            end else begin
                t_m[k]++;
            end
        end else begin
            do_pop = txenable && (q_m[k].size() > 0);
        end
        if (do_pop) begin
            b = q_m[k].pop_front();
            start_frame(k, b);
        end
        if (wr_en && !full) q_m[k].push_back(wr_data);
        if (wr_en && full) ovf_m[k] = 1'b1;
        else if (clr_ovf)  ovf_m[k] = 1'b0;
    endtask

    task automatic compare(input int k);
        logic exp_tx;
        exp_tx = busy_m[k] ? frame_m[k][t_m[k] / bdiv_m[k]] : 1'b1;
        chk("txout",    k, 32'(txout_v[k]),    32'(exp_tx));
        chk("busy",     k, 32'(busy_v[k]),     32'(busy_m[k]));
        chk("txempty",  k, 32'(txempty_v[k]),  32'((q_m[k].size() == 0) && !busy_m[k]));
        chk("wr_ready", k, 32'(wr_ready_v[k]), 32'(q_m[k].size() < DEPTH));
        chk("count",    k, 32'(get_cnt(k)),    32'(q_m[k].size()));
        chk("overflow", k, 32'(ovf_v[k]),      32'(ovf_m[k]));
    endtask

    // Model update on each edge, then compare shortly after.
    initial begin
        valid = 1'b0;
        forever begin
            @(posedge txclk);
            for (int k = 0; k < NI; k++) model_step(k);
            if (!reset) valid = 1'b1;
            #1;
            if (valid) for (int k = 0; k < NI; k++) compare(k);
        end
    end

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge txclk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (!busy_v[0] && n < 20) begin
            @(negedge txclk);
            n++;
        end
        chk("busy_start", 0, 32'(busy_v[0]), 32'd1);
    endtask

    initial begin
        logic [9:0] exp_a5;
        int nb;
        vectors = 0;
        miscompares = 0;
        reset = 1'b0; baud_div = 16'd3; wr_en = 1'b0; wr_data = '0;
        txenable = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(negedge txclk);

        // Reset values
        chk("rst_txout",    0, 32'(txout_v[0]),    32'd1);
        chk("rst_busy",     0, 32'(busy_v[0]),     32'd0);
        chk("rst_txempty",  0, 32'(txempty_v[0]),  32'd1);
        chk("rst_wr_ready", 0, 32'(wr_ready_v[0]), 32'd1);
        chk("rst_count",    0, 32'(cnt0),          32'd0);
        chk("rst_overflow", 0, 32'(ovf_v[0]),      32'd0);
        reset = 1'b1;
        @(negedge txclk);

        // 0xA5 on the line, 4 cycles per bit
        exp_a5 = 10'b11_0100_1010; // bit i = i-th line bit: 0,1,0,1,0,0,1,0,1,1
        txenable = 1'b1;
        push(8'hA5);
        wait_busy();
        nb = 0;
        for (int c = 0; c < 60; c++) begin
            if (c < 40 && (c % 4) == 0) chk("a5_bit", 0, 32'(txout_v[0]), 32'(exp_a5[c / 4]));
            if (busy_v[0]) nb++;
            @(negedge txclk);
        end
        chk("a5_busy_cycles", 0, 32'(nb), 32'd40);
        chk("a5_txempty",     0, 32'(txempty_v[0]), 32'd1);

        // Parity slot for 0x07
        push(8'h07);
        wait_busy();
        repeat (36) @(negedge txclk);
        chk("par_even", 1, 32'(txout_v[1]), 32'd1);
        chk("par_odd",  2, 32'(txout_v[2]), 32'd0);
        chk("par_none_stop", 0, 32'(txout_v[0]), 32'd1);
        repeat (40) @(negedge txclk);

        // Overflow with transmission held off
        txenable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h10 + i);
            @(negedge txclk);
        end
        wr_en = 1'b0;
        chk("ovf_count",    0, 32'(cnt0),          32'd4);
        chk("ovf_wr_ready", 0, 32'(wr_ready_v[0]), 32'd0);
        chk("ovf_set",      0, 32'(ovf_v[0]),      32'd1);
        clr_ovf = 1'b1;
        @(negedge txclk);
        clr_ovf = 1'b0;
        chk("ovf_clr", 0, 32'(ovf_v[0]), 32'd0);
        txenable = 1'b1;
        repeat (250) @(negedge txclk);
        chk("ovf_drain", 0, 32'(cnt0), 32'd0);

        // Back-to-back frames, enable dropped in the second frame
        txenable = 1'b0;
        push(8'h3C);
        push(8'hC3);
        push(8'h5A);
        txenable = 1'b1;
        wait_busy();
        for (int c = 0; c < 60; c++) begin
            if (c == 40) begin
                chk("b2b_start", 0, 32'(txout_v[0]), 32'd0);
                chk("b2b_busy",  0, 32'(busy_v[0]),  32'd1);
            end
            @(negedge txclk);
        end
        txenable = 1'b0;
        repeat (80) @(negedge txclk);
        for (int k = 0; k < NI; k++) begin
            chk("held_busy",  k, 32'(busy_v[k]), 32'd0);
            chk("held_count", k, 32'(get_cnt(k)), 32'd1);
        end

        // Reset in the middle of data bit 4
        txenable = 1'b1;
        wait_busy();
        repeat (21) @(negedge txclk);
        reset = 1'b0;
        @(negedge txclk);
        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            chk("abort_txout", k, 32'(txout_v[k]), 32'd1);
            chk("abort_busy",  k, 32'(busy_v[k]),  32'd0);
            chk("abort_count", k, 32'(get_cnt(k)), 32'd0);
        end
        repeat (60) @(negedge txclk);
        chk("abort_quiet", 0, 32'(busy_v[0]), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_data  = 8'($urandom);
            txenable = ($urandom_range(0, 7) != 0);
            clr_ovf  = ($urandom_range(0, 15) == 0);
            reset    = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 49) == 0) baud_div = 16'($urandom_range(0, 2));
            @(negedge txclk);
        end
        wr_en = 1'b0; clr_ovf = 1'b0; reset = 1'b1;
        repeat (3) @(negedge txclk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
